// File: rtl/prf_pkg.sv
// Shared PRF definitions: FSM state encoding, modulus-derived widths and the
// coefficient-width helper used by both the inner-product and rounding stages.
package prf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int N_DEFAULT = 2048;
    localparam int P_DEFAULT = 256;

    localparam int LOG2_N  = $clog2(N_DEFAULT);
    localparam int LOG2_2N = $clog2(2 * N_DEFAULT);
    localparam int LOG2_P  = $clog2(P_DEFAULT);

    // Residues mod 2N need one bit more than log2(N).
    function automatic int coef_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/prf_inner_product_if.sv
// Coefficient-in / result-out handshake bundle for the PRF inner-product engine.
interface prf_inner_product_if #(
    parameter int COEF_WIDTH = 12,
    parameter int ACC_WIDTH  = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [COEF_WIDTH-1:0] in_a;
    logic [COEF_WIDTH-1:0] in_s;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  inner_product;
    logic                  len_err;

    modport master (
        output in_valid, in_a, in_s, in_last, out_ready,
        input  in_ready, out_valid, inner_product, len_err
    );

    modport slave (
        input  in_valid, in_a, in_s, in_last, out_ready,
        output in_ready, out_valid, inner_product, len_err
    );
endinterface

// File: rtl/prf_mac_lane.sv
// Multiply-accumulate lane: full-width product and a wrap-around accumulator
// that can be cleared on the same edge that the final product is consumed.
module prf_mac_lane #(
    parameter int COEF_WIDTH = 12,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COEF_WIDTH-1:0] a_i,
    input  logic [COEF_WIDTH-1:0] s_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    output logic [ACC_WIDTH-1:0]  sum_o
);

    localparam int PROD_W = 2 * COEF_WIDTH;
    localparam int WIDE_W = (PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH;

    logic [WIDE_W-1:0]    prodWide;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    // Widen before multiplying so the product is exact, then zero-extend or truncate.
    assign prodWide = WIDE_W'(a_i) * WIDE_W'(s_i);
    assign sum_o    = acc_q + prodWide[ACC_WIDTH-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/prf_inner_product.sv
// Streaming LWR inner product <a,s>: sums K coefficient products and holds the
// result for the rounding stage until it is accepted.
module prf_inner_product
    import prf_pkg::*;
#(
    parameter int N          = 2048,
    parameter int K          = 512,
    parameter int COEF_WIDTH = coef_width(N),
    parameter int ACC_WIDTH  = 32
) (
    input logic                clk,
    input logic                rst,
    prf_inner_product_if.slave bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ACCUM = ACCUM;
    localparam logic [1:0] S_HOLD  = HOLD;

    localparam int                CNT_W    = $clog2(K);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic [ACC_WIDTH-1:0] laneSum;
    logic                 inReady;
    logic                 inFire;
    logic                 outFire;
    logic                 lastBeat;

    // Ready depends only on registered state, so out_ready never reaches in_ready.
    assign inReady  = (state_q != S_HOLD);
    assign inFire   = bus.in_valid & inReady;
    assign outFire  = (state_q == S_HOLD) & bus.out_ready;
    assign lastBeat = (count_q == LAST_CNT);

    prf_mac_lane #(
        .COEF_WIDTH(COEF_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .a_i    (bus.in_a),
        .s_i    (bus.in_s),
        .en_i   (inFire),
        .clear_i(inFire & lastBeat),
        .sum_o  (laneSum)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (inFire) begin
                    if (lastBeat) begin
                        state_d  = S_HOLD;
                        count_d  = '0;
                        result_d = laneSum;
                    end else begin
                        state_d  = S_ACCUM;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (outFire) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Length is decided by the counter alone; in_last is only cross-checked.
    assign bus.len_err       = inFire & (bus.in_last != lastBeat);
    assign bus.in_ready      = inReady;
    assign bus.out_valid     = (state_q == S_HOLD);
    assign bus.inner_product = result_q;

endmodule
